lock_controller: RTL

LOCK_CONTROLLER -- requirements
Module: lock_controller

---
 rtl/lock_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/lock_controller.sv
// Code lock FSM: synchronized switches/button, timed open, alarm and lockout.
// Ports: clk, rst_n, q/u/n/b code switches, d unlock button,
//   prog program button (only with LOCK_PROG_EN), led1/led2 active-low
//   open/alarm LEDs, state, fail_cnt. Macro LOCK_PROG_EN adds code programming.
module lock_controller #(
  parameter logic [3:0] DEFAULT_CODE = 4'b0101,
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_TICKS  = 50000000,
  parameter int ALARM_TICKS = 25000000,
  parameter int LOCK_TICKS  = 250000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       q,
  input  logic       u,
  input  logic       n,
  input  logic       b,
  input  logic       d,
`ifdef LOCK_PROG_EN
  input  logic       prog,
`endif
  output logic       led1,
  output logic       led2,
  output logic [2:0] state,
  output logic [2:0] fail_cnt
);

  localparam int MAXT0 = (OPEN_TICKS > ALARM_TICKS) ? OPEN_TICKS : ALARM_TICKS;
  localparam int MAXT  = (MAXT0 > LOCK_TICKS) ? MAXT0 : LOCK_TICKS;
  localparam int TW    = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_TICKS - 1);
  localparam logic [TW-1:0] ALARM_LD = TW'(ALARM_TICKS - 1);
  localparam logic [TW-1:0] LOCK_LD  = TW'(LOCK_TICKS - 1);
  localparam logic [3:0]    MAXF     = 4'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_OPEN  = 3'd2,
    S_FAIL  = 3'd3,
    S_LOCK  = 3'd4
  } state_e;

  state_e          state_q;
  logic [2:0]      fail_q;
  logic [TW-1:0]   timer_q;
  logic            open_q;
  logic            alarm_q;

  logic            d_s1_q, d_s2_q, d_edge_q;
  logic [3:0]      code_s1_q, code_s2_q;
  logic [3:0]      code_ref;
  logic            press;
  logic            prog_press;
  logic [3:0]      fail_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_s1_q    <= 1'b0;
      d_s2_q    <= 1'b0;
      d_edge_q  <= 1'b0;
      code_s1_q <= 4'b0;
      code_s2_q <= 4'b0;
    end else begin
      d_s1_q    <= d;
      d_s2_q    <= d_s1_q;
      d_edge_q  <= d_s2_q;
      code_s1_q <= {q, u, n, b};
      code_s2_q <= code_s1_q;
    end
  end

  assign press = d_s2_q & ~d_edge_q;

`ifdef LOCK_PROG_EN
  logic p_s1_q, p_s2_q, p_edge_q;
  logic [3:0] code_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1_q   <= 1'b0;
      p_s2_q   <= 1'b0;
      p_edge_q <= 1'b0;
    end else begin
      p_s1_q   <= prog;
      p_s2_q   <= p_s1_q;
      p_edge_q <= p_s2_q;
    end
  end

  assign prog_press = p_s2_q & ~p_edge_q;

  // Code register only changes on a programming press while open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= DEFAULT_CODE;
    end else if (state_q == S_OPEN && prog_press) begin
      code_q <= code_s2_q;
    end
  end

  assign code_ref = code_q;
`else
  assign prog_press = 1'b0;
  assign code_ref   = DEFAULT_CODE;
`endif

  assign fail_inc = {1'b0, fail_q} + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fail_q  <= 3'd0;
      timer_q <= '0;
      open_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (press) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (code_s2_q == code_ref) begin
            state_q <= S_OPEN;
            fail_q  <= 3'd0;
            timer_q <= OPEN_LD;
            open_q  <= 1'b1;
          end else if (fail_inc == MAXF) begin
            state_q <= S_LOCK;
            fail_q  <= fail_inc[2:0];
            timer_q <= LOCK_LD;
            alarm_q <= 1'b1;
          end else begin
            state_q <= S_FAIL;
            fail_q  <= fail_inc[2:0];
            timer_q <= ALARM_LD;
            alarm_q <= 1'b1;
          end
        end
        S_OPEN: begin
          // Relock or reprogram drops whatever time is left.
          if (press || prog_press || timer_q == '0) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            open_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_FAIL: begin
          if (timer_q == '0) begin
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_LOCK: begin
          if (timer_q == '0) begin
            state_q <= S_IDLE;
            fail_q  <= 3'd0;
            alarm_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          timer_q <= '0;
          open_q  <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign led1     = ~open_q;
  assign led2     = ~alarm_q;
  assign state    = state_q;
  assign fail_cnt = fail_q;

endmodule
